// File: rtl/lc3_execute.sv
// lc3_execute -- execute stage of the LC3 pipeline.
//
// Sits between decode and writeback. It selects the operands, runs the ALU and
// the address adder, and registers the results for writeback and memory access.
// Latency is one cycle. When enable_execute is low, every registered output
// holds its value.
//
// Optional feature: define LC3_EXEC_BYPASS_EN to build the operand forwarding
// muxes (previous aluout and Mem_Bypass_Val). When it is not defined, the four
// bypass inputs are ignored and the operands always come from vsr1/vsr2.
//
// Ports:
//   clock            in   1  rising-edge clock
//   reset            in   1  asynchronous, active-low; clears all registered outputs
//   enable_execute   in   1  1 = capture a new instruction, 0 = hold
//   E_Control        in   6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   IR               in  16  decoded instruction
//   npc_in           in  16  PC+1 of the instruction
//   W_Control_in     in   2  writeback control, passed through a register
//   Mem_Control_in   in   1  memory control, passed through a register
//   vsr1, vsr2       in  16  register-file read data
//   bypass_alu_1/2   in   1  select previous aluout for operand 1/2
//   bypass_mem_1/2   in   1  select Mem_Bypass_Val for operand 1/2
//   Mem_Bypass_Val   in  16  memory-stage forwarding value
//   aluout           out 16  registered ALU result (address result for LEA)
//   pcout            out 16  registered address result
//   dr               out  3  registered destination register IR[11:9]
//   IR_Exec          out 16  registered copy of IR
//   NZP              out  3  registered branch condition mask
//   M_Data           out 16  registered store data (operand 2)
//   W_Control_out    out  2  registered W_Control_in
//   Mem_Control_out  out  1  registered Mem_Control_in
//   sr1, sr2         out  3  combinational source-register indices
module lc3_execute (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [5:0]  E_Control,
  input  logic [15:0] IR,
  input  logic [15:0] npc_in,
  input  logic [1:0]  W_Control_in,
  input  logic        Mem_Control_in,
  input  logic [15:0] vsr1,
  input  logic [15:0] vsr2,
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  input  logic        bypass_mem_1,
  input  logic        bypass_mem_2,
  input  logic [15:0] Mem_Bypass_Val,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [2:0]  dr,
  output logic [15:0] IR_Exec,
  output logic [2:0]  NZP,
  output logic [15:0] M_Data,
  output logic [1:0]  W_Control_out,
  output logic        Mem_Control_out,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [1:0]  alu_control;
  logic [1:0]  pcselect1;
  logic        pcselect2;
  logic        op2select;
  logic [3:0]  opcode;

  logic [15:0] op1, op2, alu_b, alu_res, addr_base, pc_res;
  logic signed [15:0] imm5_s, off11_s, off9_s, off6_s, addr_off_s;

  logic [15:0] aluout_q, aluout_d;
  logic [15:0] pcout_q, pcout_d;
  logic [2:0]  dr_q, dr_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [15:0] mdata_q, mdata_d;
  logic [1:0]  wctl_q, wctl_d;
  logic        mctl_q, mctl_d;

  assign {alu_control, pcselect1, pcselect2, op2select} = E_Control;
  assign opcode = IR[15:12];

  // Stores read the data register from IR[11:9] instead of IR[2:0].
  assign sr1 = IR[8:6];
  assign sr2 = (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI) ? IR[11:9] : IR[2:0];

`ifdef LC3_EXEC_BYPASS_EN
  // Forwarding reads the aluout register directly, so back-to-back dependent
  // ALU ops need no stall. The ALU bypass takes priority over the memory bypass.
  assign op1 = bypass_alu_1 ? aluout_q : (bypass_mem_1 ? Mem_Bypass_Val : vsr1);
  assign op2 = bypass_alu_2 ? aluout_q : (bypass_mem_2 ? Mem_Bypass_Val : vsr2);
`else
  logic unused_bypass;
  assign unused_bypass = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, Mem_Bypass_Val};
  assign op1 = vsr1;
  assign op2 = vsr2;
`endif

  assign imm5_s  = {{11{IR[4]}}, IR[4:0]};
  assign off11_s = {{5{IR[10]}}, IR[10:0]};
  assign off9_s  = {{7{IR[8]}}, IR[8:0]};
  assign off6_s  = {{10{IR[5]}}, IR[5:0]};

  assign alu_b = op2select ? op2 : imm5_s;

  always_comb begin
    alu_res = op1;
    unique case (alu_control)
      2'b00:   alu_res = op1 + alu_b;
      2'b01:   alu_res = op1 & alu_b;
      2'b10:   alu_res = ~op1;
      default: alu_res = op1;
    endcase
  end

  always_comb begin
    addr_off_s = '0;
    unique case (pcselect1)
      2'b00:   addr_off_s = off11_s;
      2'b01:   addr_off_s = off9_s;
      2'b10:   addr_off_s = off6_s;
      default: addr_off_s = '0;
    endcase
  end

  assign addr_base = pcselect2 ? npc_in : op1;
  assign pc_res    = addr_base + addr_off_s;

  always_comb begin
    aluout_d = (opcode == OP_LEA) ? pc_res : alu_res;
    pcout_d  = pc_res;
    dr_d     = IR[11:9];
    ir_d     = IR;
    mdata_d  = op2;
    wctl_d   = W_Control_in;
    mctl_d   = Mem_Control_in;
    nzp_d    = 3'b000;
    if (opcode == OP_BR)       nzp_d = IR[11:9];
    else if (opcode == OP_JMP) nzp_d = 3'b111;
  end

  // Stage boundary: execute -> writeback/memory.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aluout_q <= '0;
      pcout_q  <= '0;
      dr_q     <= '0;
      ir_q     <= '0;
      nzp_q    <= '0;
      mdata_q  <= '0;
      wctl_q   <= '0;
      mctl_q   <= 1'b0;
    end else if (enable_execute) begin
      aluout_q <= aluout_d;
      pcout_q  <= pcout_d;
      dr_q     <= dr_d;
      ir_q     <= ir_d;
      nzp_q    <= nzp_d;
      mdata_q  <= mdata_d;
      wctl_q   <= wctl_d;
      mctl_q   <= mctl_d;
    end
  end

  assign aluout          = aluout_q;
  assign pcout           = pcout_q;
  assign dr              = dr_q;
  assign IR_Exec         = ir_q;
  assign NZP             = nzp_q;
  assign M_Data          = mdata_q;
  assign W_Control_out   = wctl_q;
  assign Mem_Control_out = mctl_q;

endmodule
